// File: rtl/pwm_duty_generator.sv
// PWM waveform generator with a duty handshake and prescaled tick.
// A new duty applies at period boundaries, optionally slew-limited per period.
module pwm_duty_generator #(
    parameter int WIDTH     = 10,
    parameter int PRESCALE  = 50,
    parameter int TOP       = 999,
    parameter int RAMP_STEP = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_end,
    output logic [WIDTH-1:0] duty_active,
    output logic             busy
);

    localparam int               PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_TOP    = WIDTH'(TOP);
    localparam logic [WIDTH-1:0] DUTY_MAX   = WIDTH'(TOP + 1);
    localparam logic [WIDTH:0]   STEP_W     = (WIDTH + 1)'(RAMP_STEP);

    logic [PW-1:0]    presc_cnt_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] target_r;
    logic [WIDTH-1:0] duty_active_r;
    logic             pending_r;
    logic             pwm_out_r;
    logic             period_end_r;

    logic             tick_s;
    logic             wrap_s;
    logic             accept_s;
    logic [WIDTH-1:0] duty_clamped_s;
    logic [WIDTH-1:0] ramp_next_s;
    logic [WIDTH:0]   up_sum_s;
    logic [WIDTH:0]   dn_limit_s;

    assign tick_s   = enable && (presc_cnt_r == PRESC_LAST);
    assign wrap_s   = tick_s && (cnt_r == CNT_TOP);
    assign accept_s = duty_valid && !pending_r;

    // Clamp the requested duty to a full period (constant high).
    always_comb begin
        duty_clamped_s = duty_in;
        if (duty_in > DUTY_MAX) begin
            duty_clamped_s = DUTY_MAX;
        end else begin
            duty_clamped_s = duty_in;
        end
    end

    // Next active duty: one bounded step toward target, computed one bit wide so it never wraps.
    always_comb begin
        ramp_next_s = duty_active_r;
        up_sum_s    = {1'b0, duty_active_r} + STEP_W;
        dn_limit_s  = {1'b0, target_r} + STEP_W;
        if (RAMP_STEP == 0) begin
            ramp_next_s = target_r;
        end else if (duty_active_r < target_r) begin
            if (up_sum_s >= {1'b0, target_r}) begin
                ramp_next_s = target_r;
            end else begin
                ramp_next_s = WIDTH'(up_sum_s);
            end
        end else if (duty_active_r > target_r) begin
            if ({1'b0, duty_active_r} <= dn_limit_s) begin
                ramp_next_s = target_r;
            end else begin
                ramp_next_s = WIDTH'({1'b0, duty_active_r} - STEP_W);
            end
        end else begin
            ramp_next_s = duty_active_r;
        end
    end

    // Prescaler, period counter and period-end pulse; all held at zero while disabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_cnt_r  <= {PW{1'b0}};
            cnt_r        <= {WIDTH{1'b0}};
            period_end_r <= 1'b0;
        end else if (!enable) begin
            presc_cnt_r  <= {PW{1'b0}};
            cnt_r        <= {WIDTH{1'b0}};
            period_end_r <= 1'b0;
        end else begin
            if (tick_s) begin
                presc_cnt_r <= {PW{1'b0}};
            end else begin
                presc_cnt_r <= presc_cnt_r + PW'(1);
            end
            if (wrap_s) begin
                cnt_r <= {WIDTH{1'b0}};
            end else if (tick_s) begin
                cnt_r <= cnt_r + WIDTH'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            period_end_r <= wrap_s;
        end
    end

    // Registered waveform compare.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_out_r <= 1'b0;
        end else begin
            pwm_out_r <= enable && (cnt_r < duty_active_r);
        end
    end

    // Handshake and ramp; duty changes on the wrap edge so it lands exactly at cnt=0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            target_r      <= {WIDTH{1'b0}};
            duty_active_r <= {WIDTH{1'b0}};
            pending_r     <= 1'b0;
        end else begin
            if (wrap_s && pending_r) begin
                duty_active_r <= ramp_next_s;
                if (ramp_next_s == target_r) begin
                    pending_r <= 1'b0;
                end else begin
                    pending_r <= 1'b1;
                end
            end else begin
                duty_active_r <= duty_active_r;
            end
            // Only reachable with pending low, so it never collides with the clear above.
            if (accept_s) begin
                target_r  <= duty_clamped_s;
                pending_r <= 1'b1;
            end else begin
                target_r <= target_r;
            end
        end
    end

    assign duty_ready  = !pending_r;
    assign busy        = pending_r;
    assign pwm_out     = pwm_out_r;
    assign period_end  = period_end_r;
    assign duty_active = duty_active_r;

endmodule
